spi_ram_ctrl: RTL

Parametrised command-decoding RAM behind the SPI slave front end. It takes framed words of the form {cmd[1:0], payload} from the SPI receive path and executes them against an internal synchronous memory. The four commands are load write address, write data, load read address and read data. It adds over the previous generation:
- separate write and read address pointers
- optional address auto-increment for burst transfers
- a valid/ready return handshake toward the SPI transmit path
- sticky error flags

---
 rtl/spi_ram_pkg.sv | 14 +
 rtl/spi_ram_ctrl_if.sv | 28 ++
 rtl/spi_ram_mem.sv | 23 ++
 rtl/spi_ram_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command encoding for the SPI-attached RAM controller.
// The command field sits in the top CMD_W bits of every received frame.
package spi_ram_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Bundles the SPI receive-side command stream, the transmit-side return handshake
// and the status flags between the SPI front end and the RAM controller.
interface spi_ram_ctrl_if
  import spi_ram_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic [DATA_W+CMD_W-1:0] rx_data;
  logic                    rx_valid;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    busy;
  logic                    addr_err;
  logic                    drop_err;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, busy, addr_err, drop_err
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, busy, addr_err, drop_err
  );

endinterface

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with a registered read port; contents are never reset.
module spi_ram_mem #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder in front of spi_ram_mem: write/read pointers with optional
// auto-increment, a valid/ready return path for read data, and sticky error flags.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic           clk,
  input  logic           rst,
  spi_ram_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  cmd_e              cmd;
  logic [DATA_W-1:0] payload;
  logic              addrOk;

  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic              txValid_q, txValid_d;
  logic              rdPending_q, rdPending_d;
  logic [DATA_W-1:0] txHold_q, txHold_d;
  logic              addrErr_q, addrErr_d;
  logic              dropErr_q, dropErr_d;

  logic              memWe;
  logic              rdAccept;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memRdata;

  function automatic logic [ADDR_W-1:0] incPtr(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  assign cmd     = cmd_e'(bus.rx_data[DATA_W+CMD_W-1:DATA_W]);
  assign payload = bus.rx_data[DATA_W-1:0];
  assign addrOk  = ((payload >> ADDR_W) == '0) && ({1'b0, payload[ADDR_W-1:0]} < DEPTH_EXT);

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    txValid_d = txValid_q;
    addrErr_d = addrErr_q;
    dropErr_d = dropErr_q;
    memWe     = 1'b0;
    memAddr   = rdPtr_q;
    rdAccept  = 1'b0;

    if (bus.rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: begin
          if (addrOk) wrPtr_d = payload[ADDR_W-1:0];
          else        addrErr_d = 1'b1;
        end
        CMD_WR_DATA: begin
          memWe   = 1'b1;
          memAddr = wrPtr_q;
          if (AUTO_INC != 0) wrPtr_d = incPtr(wrPtr_q);
        end
        CMD_RD_ADDR: begin
          if (addrOk) rdPtr_d = payload[ADDR_W-1:0];
          else        addrErr_d = 1'b1;
        end
        CMD_RD_DATA: begin
          if (!txValid_q || bus.tx_ready) begin
            rdAccept = 1'b1;
            if (AUTO_INC != 0) rdPtr_d = incPtr(rdPtr_q);
          end else begin
            dropErr_d = 1'b1;
          end
        end
      endcase
    end

    // A new read keeps tx_valid high even when the previous word is accepted this cycle
    if (rdAccept)          txValid_d = 1'b1;
    else if (bus.tx_ready) txValid_d = 1'b0;

    rdPending_d = rdAccept;
    txHold_d    = rdPending_q ? memRdata : txHold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      txValid_q   <= 1'b0;
      rdPending_q <= 1'b0;
      txHold_q    <= '0;
      addrErr_q   <= 1'b0;
      dropErr_q   <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      txValid_q   <= txValid_d;
      rdPending_q <= rdPending_d;
      txHold_q    <= txHold_d;
      addrErr_q   <= addrErr_d;
      dropErr_q   <= dropErr_d;
    end
  end

  spi_ram_mem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (memWe && !rst),
    .addr_i (memAddr),
    .wdata_i(payload),
    .rdata_o(memRdata)
  );

  // The RAM output is only meaningful the cycle after a read; afterwards the held copy is shown
  assign bus.tx_data  = rdPending_q ? memRdata : txHold_q;
  assign bus.tx_valid = txValid_q;
  assign bus.busy     = txValid_q;
  assign bus.addr_err = addrErr_q;
  assign bus.drop_err = dropErr_q;

endmodule
